// File: rtl/ws2812_pkg.sv
// Shared WS2812/SK6812 timing and colour-order definitions for the LED transmitter and receiver.
package ws2812_pkg;

    function automatic int CYCLE_COUNT(input int sys_clk);
        return sys_clk / 800000;
    endfunction

    function automatic int H0(input int sys_clk);
        return CYCLE_COUNT(sys_clk) / 4;
    endfunction

    function automatic int H1(input int sys_clk);
        return CYCLE_COUNT(sys_clk) / 2;
    endfunction

    // Decision point sits midway between the H0 and H1 high times.
    function automatic int THRESH(input int sys_clk);
        return (CYCLE_COUNT(sys_clk) * 3) / 8;
    endfunction

    function automatic int MIN_HIGH(input int sys_clk);
        return CYCLE_COUNT(sys_clk) / 8;
    endfunction

    function automatic int MAX_HIGH(input int sys_clk);
        return CYCLE_COUNT(sys_clk);
    endfunction

    // Shorter than the transmitter's latch so a loopback always closes the frame.
    function automatic int GAP_COUNT(input int sys_clk);
        return 50 * CYCLE_COUNT(sys_clk);
    endfunction

    // Byte position of each colour in the 24-bit word, green sent first.
    localparam int COLOR_G = 2;
    localparam int COLOR_R = 1;
    localparam int COLOR_B = 0;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ws2812_rx_if.sv
// Pixel/frame output bundle of the WS2812 receiver.
interface ws2812_rx_if #(
    parameter int NUM_LEDS = 8
);
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CW = $clog2(NUM_LEDS + 1);

    logic          pixel_valid_o;
    logic [AW-1:0] address_o;
    logic [7:0]    green_o;
    logic [7:0]    red_o;
    logic [7:0]    blue_o;
    logic          frame_done_o;
    logic [CW-1:0] led_count_o;
    logic          overflow_o;
    logic          error_o;
    logic          busy_o;

    modport master (
        output pixel_valid_o, address_o, green_o, red_o, blue_o,
        output frame_done_o, led_count_o, overflow_o, error_o, busy_o
    );

    modport slave (
        input pixel_valid_o, address_o, green_o, red_o, blue_o,
        input frame_done_o, led_count_o, overflow_o, error_o, busy_o
    );
endinterface

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchroniser for the asynchronous data line plus one edge-detect register.
module ws2812_rx_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic di_i,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= di_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
endmodule

// File: rtl/ws2812_rx.sv
// WS2812/SK6812 stream decoder: per-LED GRB pixel strobes and latch-gap frame reporting.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int SYSTEM_CLOCK = 50000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic di_i,
    ws2812_rx_if.master px
);
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CW = $clog2(NUM_LEDS + 1);
    localparam int PW = $clog2(NUM_LEDS + 2);
    localparam int HW = $clog2(MAX_HIGH(SYSTEM_CLOCK) + 1);
    localparam int LW = $clog2(GAP_COUNT(SYSTEM_CLOCK) + 1);

    localparam logic [HW-1:0] THR_C   = HW'(THRESH(SYSTEM_CLOCK));
    localparam logic [HW-1:0] MINH_C  = HW'(MIN_HIGH(SYSTEM_CLOCK));
    localparam logic [HW-1:0] MAXH_C  = HW'(MAX_HIGH(SYSTEM_CLOCK));
    localparam logic [LW-1:0] GAPL_C  = LW'(GAP_COUNT(SYSTEM_CLOCK) - 1);
    localparam logic [PW-1:0] NLEDS_C = PW'(NUM_LEDS);

    logic level, rise, fall;

    ws2812_rx_sync u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .di_i    (di_i),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    rx_state_e state, state_next;

    logic [HW-1:0] hi_cnt;
    logic [LW-1:0] lo_cnt;
    logic [4:0]    bit_cnt;
    logic [PW-1:0] pix_cnt;
    logic [23:0]   sr;
    logic          pix_pend;

    logic hi_clr, hi_inc, lo_clr, lo_inc, shift_en, drop, latch, abort, err;

    logic          pixel_valid, frame_done, overflow, error;
    logic [AW-1:0] address;
    logic [7:0]    green, red, blue;
    logic [CW-1:0] led_count;

    function automatic logic [CW-1:0] sat_count(input logic [PW-1:0] n);
        return (n > NLEDS_C) ? CW'(NUM_LEDS) : n[CW-1:0];
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= SYNC;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        hi_clr     = 1'b0;
        hi_inc     = 1'b0;
        lo_clr     = 1'b0;
        lo_inc     = 1'b0;
        shift_en   = 1'b0;
        drop       = 1'b0;
        latch      = 1'b0;
        abort      = 1'b0;
        err        = 1'b0;
        case (state)
            SYNC: begin
                if (level) begin
                    lo_clr = 1'b1;
                end else if (lo_cnt == GAPL_C) begin
                    lo_clr     = 1'b1;
                    state_next = IDLE;
                end else begin
                    lo_inc = 1'b1;
                end
            end
            IDLE: begin
                if (rise) begin
                    hi_clr     = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    lo_clr     = 1'b1;
                    state_next = LOW;
                    if (hi_cnt < MINH_C) begin
                        err  = 1'b1;
                        drop = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                    end
                end else if (hi_cnt >= MAXH_C) begin
                    // Line stuck high: resynchronise from scratch.
                    err        = 1'b1;
                    abort      = 1'b1;
                    lo_clr     = 1'b1;
                    state_next = SYNC;
                end else begin
                    hi_inc = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    hi_clr     = 1'b1;
                    state_next = HIGH;
                end else if (lo_cnt == GAPL_C) begin
                    latch      = 1'b1;
                    err        = (bit_cnt != 5'd0);
                    state_next = IDLE;
                end else begin
                    lo_inc = 1'b1;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (shift_en) sr <= {sr[22:0], (hi_cnt >= THR_C)};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            pix_pend    <= 1'b0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            error       <= 1'b0;
            address     <= '0;
            green       <= '0;
            red         <= '0;
            blue        <= '0;
            led_count   <= '0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= err;

            if (hi_clr)      hi_cnt <= '0;
            else if (hi_inc) hi_cnt <= hi_cnt + 1'b1;

            if (lo_clr)      lo_cnt <= '0;
            else if (lo_inc) lo_cnt <= lo_cnt + 1'b1;

            if (shift_en) begin
                if (bit_cnt == 5'd23) begin
                    bit_cnt  <= '0;
                    pix_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (drop) bit_cnt <= '0;

            // Present the completed word one cycle after its last bit landed.
            if (pix_pend) begin
                pix_pend <= 1'b0;
                if (pix_cnt < NLEDS_C) begin
                    pixel_valid <= 1'b1;
                    address     <= pix_cnt[AW-1:0];
                    green       <= sr[COLOR_G*8 +: 8];
                    red         <= sr[COLOR_R*8 +: 8];
                    blue        <= sr[COLOR_B*8 +: 8];
                end else begin
                    overflow <= 1'b1;
                end
                if (pix_cnt <= NLEDS_C) pix_cnt <= pix_cnt + 1'b1;
            end

            if (latch) begin
                bit_cnt <= '0;
                pix_cnt <= '0;
                address <= '0;
                if (pix_cnt != '0) begin
                    frame_done <= 1'b1;
                    led_count  <= sat_count(pix_cnt);
                    overflow   <= (pix_cnt > NLEDS_C);
                end
            end

            if (abort) begin
                bit_cnt  <= '0;
                pix_cnt  <= '0;
                pix_pend <= 1'b0;
                address  <= '0;
            end
        end
    end

    assign px.pixel_valid_o = pixel_valid;
    assign px.address_o     = address;
    assign px.green_o       = green;
    assign px.red_o         = red;
    assign px.blue_o        = blue;
    assign px.frame_done_o  = frame_done;
    assign px.led_count_o   = led_count;
    assign px.overflow_o    = overflow;
    assign px.error_o       = error;
    assign px.busy_o        = (state == HIGH) || (state == LOW);
endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Decodes a WS2812/SK6812 single-wire serial stream into per-LED 24-bit GRB pixels, one pixel-valid strobe per LED.
- Detects the latch (reset) gap that ends a frame and reports how many LEDs the frame carried.
- Sits on the monitor/loopback side of the LED chain: it checks transmitter output on-chip, and it lets the FPGA act as a pixel in a chain.

Parameters:
- NUM_LEDS, 8: maximum pixels captured per frame. Pixels beyond this are counted but not output.
- SYSTEM_CLOCK, 50000000: clk_i frequency in Hz. All timing below derives from it.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- di_i  in  1  serial data line; asynchronous to clk_i.
- pixel_valid_o  out  1  one-cycle strobe; address_o, green_o, red_o and blue_o are valid in that cycle.
- address_o  out  clog2(NUM_LEDS)  index of the pixel being presented, 0-based within the frame.
- green_o / red_o / blue_o  out  8 each  decoded colour bytes, MSB received first.
- frame_done_o  out  1  one-cycle strobe when the latch gap ends a frame containing at least 1 complete pixel.
- led_count_o  out  clog2(NUM_LEDS+1)  complete pixels in the last finished frame, saturating at NUM_LEDS; updated together with frame_done_o.
- overflow_o  out  1  sticky; set when a frame carries more than NUM_LEDS pixels; cleared by the next frame_done_o.
- error_o  out  1  one-cycle strobe on a protocol violation.
- busy_o  out  1  high while inside a frame, i.e. state HIGH or LOW.

Behaviour:
- Constants:
  - CYCLE_COUNT = SYSTEM_CLOCK/800000 (62 at 50 MHz).
  - THRESH = 0.375*CYCLE_COUNT = 23; midway between the SK6812 H0 (15) and H1 (31) high times.
  - MIN_HIGH = CYCLE_COUNT/8 = 7.
  - MAX_HIGH = CYCLE_COUNT = 62.
  - GAP_COUNT = 50*CYCLE_COUNT = 3100 low cycles, about 62 us. This is deliberately shorter than the transmitter's 100-cycle reset so a loopback always latches.
- Input path: di_i passes through a 2-flop synchroniser, then a third register for edge detection. rise = s2 & ~s3; fall = ~s2 & s3.
- Counters:
  - hi_cnt and lo_cnt each cover a full bit or gap respectively, and saturate at their maximum.
  - bit_cnt runs 0..23.
  - pix_cnt counts pixels, saturating at NUM_LEDS+1.
- States: SYNC, IDLE, HIGH, LOW.
- SYNC (entered from reset): wait for GAP_COUNT consecutive low cycles, then go to IDLE. Rises in SYNC restart the low count and never produce data.
- IDLE: on rise, clear hi_cnt and go to HIGH.
- HIGH: count hi_cnt every cycle.
  - On fall with hi_cnt < MIN_HIGH: assert error_o; discard the partial pixel (bit_cnt <= 0); go to LOW.
  - On any other fall: shift in bit (hi_cnt >= THRESH) at the LSB of a 24-bit shift register; increment bit_cnt; clear lo_cnt; go to LOW.
  - If hi_cnt reaches MAX_HIGH before the fall (line stuck high): assert error_o; abandon the frame without frame_done_o; go to SYNC.
- LOW: count lo_cnt every cycle.
  - On rise: go to HIGH.
  - When lo_cnt reaches GAP_COUNT-1 (latch detected):
    - If bit_cnt != 0: assert error_o and drop the partial pixel.
    - If pix_cnt > 0: pulse frame_done_o and load led_count_o.
    - In all cases: reset address_o, pix_cnt and bit_cnt to 0, then go to IDLE.
- Pixel completion:
  - When the 24th bit is shifted in, the next cycle pulses pixel_valid_o with green = sr[23:16], red = sr[15:8], blue = sr[7:0].
  - Also in that cycle, address_o is set to pix_cnt; pix_cnt and bit_cnt are then updated.
  - If pix_cnt >= NUM_LEDS: no pixel_valid_o strobe; set overflow_o.
- Latency: pixel_valid_o is high in the cycle starting at the 4th rising clk_i edge after di_i falls at the end of bit 24 (2 sync + 1 edge register + 1 output register). This is exact, and the bench checks it.
- Simultaneous events: frame_done_o and error_o may assert in the same cycle. pixel_valid_o and frame_done_o never coincide.
- Reset values (asserting reset_i at any time aborts any frame in progress):
  - All strobes 0; overflow_o 0; address_o 0; colour outputs 0; led_count_o 0.
  - Synchroniser flops 0; state SYNC.
- Output stability: colour outputs hold their last pixel between strobes.

Decomposition:
- Package ws2812_pkg holds:
  - The timing constant functions CYCLE_COUNT, H0, H1, THRESH, MIN_HIGH and GAP_COUNT, all derived from SYSTEM_CLOCK.
  - The colour order constants COLOR_G, COLOR_R and COLOR_B.
  - The transmitter switches to the same package.
- Sub-module ws2812_rx_sync covers the 2-flop synchroniser plus edge detect. It outputs level, rise and fall.

Test Plan:
- One pixel at SYSTEM_CLOCK=50 MHz: G=0x12 R=0x34 B=0x56 (highs of 15/31 cycles in a 62-cycle period), then a 4000-cycle low gap.
  - Required: one pixel_valid_o with address 0 and colours 0x12/0x34/0x56 at the exact latency.
  - Required: then frame_done_o with led_count_o=1.
- Loopback: drive ws2812 with led_count_i=3 and distinct colours.
  - Required: 3 strobes at addresses 0,1,2 with matching colours, then frame_done_o with led_count_o=3.
- Glitch: 3-cycle high pulse in mid-byte.
  - Required: error_o pulses and the partial pixel is dropped.
  - Required: the next full 24 bits decode correctly at the same address.
- Partial frame: 10 bits then the gap.
  - Required: error_o asserts; no pixel_valid_o; no frame_done_o.
- Overflow with NUM_LEDS=8: send 9 pixels.
  - Required: 8 strobes; overflow_o=1; led_count_o=8.
  - Required: overflow_o clears at the next frame_done_o.
- Reset: assert reset_i mid-bit during pixel 2.
  - Required: outputs return to reset values and there are no strobes.
  - Required: a new frame is decoded only after GAP_COUNT low cycles following reset release.
